// File: rtl/obj_edge_fetch.sv
// Frame-start object walker: snapshots the valid map, reads each live object record
// through the shared memory port and streams its outline edges to the rasterizer.
module obj_edge_fetch #(
  parameter  int NUM_OBJ = 32,
  parameter  int COORD_W = 16,
  localparam int IW      = $clog2(NUM_OBJ),
  localparam int REC_W   = 8*COORD_W + 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NUM_OBJ-1:0] obj_map,
  input  logic               mat_busy,
  output logic               rd_en,
  output logic [IW-1:0]      rd_addr,
  input  logic [REC_W-1:0]   rd_data,
  output logic               seg_vld,
  input  logic               seg_rdy,
  output logic [COORD_W-1:0] seg_x0,
  output logic [COORD_W-1:0] seg_y0,
  output logic [COORD_W-1:0] seg_x1,
  output logic [COORD_W-1:0] seg_y1,
  output logic [7:0]         seg_color,
  output logic [IW-1:0]      seg_obj,
  output logic               seg_last,
  output logic               busy,
  output logic               done
);

  localparam int VB = 8*COORD_W;   // vertex field width
  localparam int RB = VB + 2;      // vertices + type kept for edge generation

  typedef enum logic [2:0] {IDLE, SCAN, READ, WAIT, EMIT, DONE} state_t;

  state_t             state;
  logic [NUM_OBJ-1:0] map_q;
  logic [IW-1:0]      idx;
  logic [RB-1:0]      rec;
  logic [1:0]         e;
  logic               last_idx;
  logic               unused_hi;

  assign last_idx  = (idx == IW'(NUM_OBJ-1));
  assign rd_en     = (state == READ) && !mat_busy;
  assign rd_addr   = idx;
  assign unused_hi = ^rd_data[REC_W-1:RB+8];

  function automatic logic [2:0] nseg(input logic [1:0] ty);
    case (ty)
      2'd2:    return 3'd3;
      2'd3:    return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  // Edge k runs from vertex k to the next vertex, wrapping to V0 on the closing edge;
  // a line is the one exception, joining V0 to V1.
  function automatic logic [4*COORD_W-1:0] seg_of(input logic [RB-1:0] r, input logic [1:0] k);
    logic [1:0] b;
    if (r[VB +: 2] == 2'd1)                        b = 2'd1;
    else if ({1'b0, k} + 3'd1 == nseg(r[VB +: 2])) b = 2'd0;
    else                                           b = k + 2'd1;
    return {r[2*COORD_W*k +: COORD_W], r[2*COORD_W*k + COORD_W +: COORD_W],
            r[2*COORD_W*b +: COORD_W], r[2*COORD_W*b + COORD_W +: COORD_W]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      map_q     <= '0;
      idx       <= '0;
      rec       <= '0;
      e         <= '0;
      seg_vld   <= 1'b0;
      seg_x0    <= '0;
      seg_y0    <= '0;
      seg_x1    <= '0;
      seg_y1    <= '0;
      seg_color <= '0;
      seg_obj   <= '0;
      seg_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          map_q <= obj_map;
          idx   <= '0;
          busy  <= 1'b1;
          state <= SCAN;
        end
        SCAN: begin
          if (map_q[idx])    state <= READ;
          else if (last_idx) state <= DONE;
          else               idx   <= idx + 1'b1;
        end
        READ: if (!mat_busy) state <= WAIT;
        WAIT: begin
          rec       <= rd_data[RB-1:0];
          e         <= '0;
          {seg_x0, seg_y0, seg_x1, seg_y1} <= seg_of(rd_data[RB-1:0], 2'd0);
          seg_color <= rd_data[RB +: 8];
          seg_obj   <= idx;
          seg_last  <= (nseg(rd_data[VB +: 2]) == 3'd1);
          seg_vld   <= 1'b1;
          state     <= EMIT;
        end
        EMIT: if (seg_rdy) begin
          if (seg_last) begin
            seg_vld  <= 1'b0;
            seg_last <= 1'b0;
            if (last_idx) state <= DONE;
            else begin
              idx   <= idx + 1'b1;
              state <= SCAN;
            end
          end else begin
            e        <= e + 2'd1;
            {seg_x0, seg_y0, seg_x1, seg_y1} <= seg_of(rec, e + 2'd1);
            seg_last <= ({1'b0, e} + 3'd2 == nseg(rec[VB +: 2]));
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obj_edge_fetch.sv
// Scoreboard bench for obj_edge_fetch: a polygon-level model fills expected segment and
// read-address queues; a negedge monitor pops and compares whatever the DUT presents.
module tb_obj_edge_fetch;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  obj_map = '0;
  logic         mat_busy = 1'b0;
  logic         rd_en;
  logic [4:0]   rd_addr;
  logic [143:0] rd_data;
  logic         seg_vld;
  logic         seg_rdy = 1'b0;
  logic [15:0]  seg_x0, seg_y0, seg_x1, seg_y1;
  logic [7:0]   seg_color;
  logic [4:0]   seg_obj;
  logic         seg_last, busy, done;

  obj_edge_fetch #(.NUM_OBJ(32), .COORD_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .obj_map(obj_map), .mat_busy(mat_busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .seg_vld(seg_vld),
    .seg_rdy(seg_rdy), .seg_x0(seg_x0), .seg_y0(seg_y0), .seg_x1(seg_x1),
    .seg_y1(seg_y1), .seg_color(seg_color), .seg_obj(seg_obj), .seg_last(seg_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] x0, y0, x1, y1;
    logic [7:0]  col;
    logic [4:0]  obj;
    logic        last;
  } seg_t;

  seg_t              exp_q[$];
  int                exp_addr[$];
  int                checks = 0;
  int                errors = 0;
  int                done_cnt = 0;
  logic [7:0][15:0]  mem_v [32];
  logic [1:0]        mem_ty [32];
  logic [7:0]        mem_col [32];
  logic [143:0]      mem_rec [32];

  // Video memory: one-cycle read latency, junk on idle cycles to expose early capture.
  always @(posedge clk) rd_data <= rd_en ? mem_rec[rd_addr] : ~mem_rec[rd_addr];

  int rdy_mode = 0;
  int pat = 0;
  bit busy_mode = 1'b0;
  bit busy_force = 1'b0;

  always @(posedge clk) begin
    #1;
    pat++;
    case (rdy_mode)
      0:       seg_rdy = 1'b1;
      1:       seg_rdy = (pat % 3 == 0);
      2:       seg_rdy = 1'($urandom_range(0, 1));
      default: seg_rdy = 1'b0;
    endcase
    mat_busy = busy_mode ? 1'($urandom_range(0, 1)) : busy_force;
  end

  seg_t prev;
  bit   hold = 1'b0;

  always @(negedge clk) begin
    seg_t cur, ex;
    int   a;
    cur = '{seg_x0, seg_y0, seg_x1, seg_y1, seg_color, seg_obj, seg_last};
    if (!rst_n) hold = 1'b0;
    else begin
      if (done) done_cnt++;
      if (rd_en) begin
        checks++;
        if (mat_busy) begin
          errors++;
          $display("FAIL rd_en_while_mat_busy addr=%0d", rd_addr);
        end else if (exp_addr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rd_en addr=%0d", rd_addr);
        end else begin
          a = exp_addr.pop_front();
          if (rd_addr !== 5'(a)) begin
            errors++;
            $display("FAIL rd_addr act=%0d exp=%0d", rd_addr, a);
          end
        end
      end
      if (hold) begin
        checks++;
        if (seg_vld !== 1'b1 || cur !== prev) begin
          errors++;
          $display("FAIL seg_hold act=%h vld=%b exp=%h", cur, seg_vld, prev);
        end
      end
      if (seg_vld && seg_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_seg act=%h", cur);
        end else begin
          ex = exp_q.pop_front();
          if (cur !== ex) begin
            errors++;
            $display("FAIL seg act=%h exp=%h", cur, ex);
          end
        end
      end
      hold = seg_vld && !seg_rdy;
      prev = cur;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic load_slot(input int s, input logic [1:0] ty, input logic [7:0] col,
                           input logic [7:0][15:0] v);
    mem_v[s]   = v;
    mem_ty[s]  = ty;
    mem_col[s] = col;
    mem_rec[s] = {6'($urandom), col, ty, v};
  endtask

  // Outline of each live object: a point is a degenerate edge, a line one edge,
  // triangles and quads closed polygons over their first 3/4 vertices.
  task automatic push_model(input logic [31:0] map, output int cyc);
    int nv, ns, b;
    cyc = 33;
    for (int s = 0; s < 32; s++) begin
      if (map[s]) begin
        exp_addr.push_back(s);
        nv = (mem_ty[s] == 0) ? 1 : (mem_ty[s] == 1) ? 2 : int'(mem_ty[s]) + 1;
        ns = (mem_ty[s] <= 1) ? 1 : nv;
        for (int i = 0; i < ns; i++) begin
          b = (i + 1) % nv;
          exp_q.push_back('{mem_v[s][2*i], mem_v[s][2*i+1], mem_v[s][2*b], mem_v[s][2*b+1],
                            mem_col[s], 5'(s), (i == ns - 1)});
        end
        cyc += 2 + ns;
      end
    end
  endtask

  task automatic run_frame(input logic [31:0] map, input bit check_lat);
    int exp_cyc, cnt, d0;
    push_model(map, exp_cyc);
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1; obj_map = map;
    @(posedge clk); #1 start = 1'b0; obj_map = $urandom;
    chk("busy_rise", busy, 1);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!done && cnt < 5000);
    if (!done) begin
      errors++;
      $display("FAIL done_timeout act=%0d exp=%0d", cnt, exp_cyc);
    end
    if (check_lat) chk("done_latency", cnt, exp_cyc);
    chk("busy_fall_with_done", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("done_once", done_cnt - d0, 1);
    chk("seg_queue_drained", exp_q.size(), 0);
    chk("rd_queue_drained", exp_addr.size(), 0);
    exp_q.delete();
    exp_addr.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, cnt;
    for (int s = 0; s < 32; s++) load_slot(s, 2'($urandom), 8'($urandom),
                                           {$urandom, $urandom, $urandom, $urandom});

    // Reset under random inputs
    rdy_mode = 2; busy_mode = 1'b1;
    repeat (6) begin
      @(posedge clk); #1 start = 1'($urandom); obj_map = $urandom;
    end
    chk("rst_ctrl", {seg_vld, rd_en, busy, done, seg_last}, 0);
    chk("rst_coords", {seg_x0, seg_y0, seg_x1, seg_y1}, 0);
    chk("rst_misc", {seg_color, seg_obj, rd_addr}, 0);
    start = 1'b0; obj_map = '0;
    @(posedge clk); #1 rst_n = 1'b1; rdy_mode = 0; busy_mode = 1'b0;
    repeat (2) @(posedge clk);

    // Empty map: pure scan
    run_frame(32'h0, 1);

    // Square quad in slot 0
    load_slot(0, 2'd3, 8'h3C, {16'd100, 16'd200, 16'd200, 16'd200,
                               16'd200, 16'd100, 16'd100, 16'd100});
    run_frame(32'h1, 1);

    // Quad, triangle, line in slots 0..2
    load_slot(1, 2'd2, 8'h51, {$urandom, $urandom, $urandom, $urandom});
    load_slot(2, 2'd1, 8'hA7, {$urandom, $urandom, $urandom, $urandom});
    run_frame(32'h7, 1);

    // Backpressure on a quad in slot 5
    load_slot(5, 2'd3, 8'h0F, {$urandom, $urandom, $urandom, $urandom});
    rdy_mode = 1;
    run_frame(32'h20, 0);
    rdy_mode = 0;

    // Port contention in READ plus an ignored second start
    load_slot(3, 2'd3, 8'h99, {$urandom, $urandom, $urandom, $urandom});
    busy_force = 1'b1;
    fork
      run_frame(32'h8, 0);
      begin
        repeat (10) @(posedge clk);
        #1 start = 1'b1; obj_map = '1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 chk("rd_stalled_by_mat_busy", exp_addr.size(), 1);
        busy_force = 1'b0;
      end
    join

    // Point in slot 31
    load_slot(31, 2'd0, 8'h44, {96'd0, 16'd9, 16'd7});
    run_frame(32'h8000_0000, 1);

    // Reset mid-EMIT
    load_slot(2, 2'd3, 8'h12, {$urandom, $urandom, $urandom, $urandom});
    rdy_mode = 3;
    exp_addr.push_back(2);
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1; obj_map = 32'h4;
    @(posedge clk); #1 start = 1'b0;
    cnt = 0;
    while (!seg_vld && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("emit_reached", seg_vld, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {seg_vld, rd_en, busy, done, seg_last}, 0);
    chk("midrst_coords", {seg_x0, seg_y0, seg_x1, seg_y1, seg_color, seg_obj}, 0);
    exp_q.delete();
    exp_addr.delete();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1 chk("no_done_after_reset", done_cnt - d0, 0);

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      bit lat;
      for (int s = 0; s < 32; s++) load_slot(s, 2'($urandom), 8'($urandom),
                                             {$urandom, $urandom, $urandom, $urandom});
      rdy_mode  = $urandom_range(0, 2);
      busy_mode = 1'($urandom_range(0, 1));
      lat = (rdy_mode == 0) && !busy_mode;
      run_frame((f % 2 == 0) ? $urandom : ($urandom & $urandom), lat);
    end
    rdy_mode = 0; busy_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obj_edge_fetch.md
# obj_edge_fetch

Downstream consumer of the video memory object store. On a frame start it snapshots the object-valid bitmap `obj_map` from the object unit. It then walks slots 0..31, reads each valid 144-bit object record through the read port shared with the matrix unit, and emits the object's edges as segments (two endpoints plus colour) to the rasterizer over a valid/ready handshake.

## Interface
Parameters:
- `NUM_OBJ`, 32: object slots; `rd_addr` width is log2(`NUM_OBJ`) = 5.
- `COORD_W`, 16: width of each vertex coordinate.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: frame start pulse; honoured only in IDLE.
- `obj_map` in 32: bit n set = slot n holds a valid object; sampled on accepted `start`.
- `mat_busy` in 1: matrix unit owns the memory port; no read issued while high.
- `rd_en` out 1: read strobe to video memory, one cycle per object.
- `rd_addr` out 5: slot being read.
- `rd_data` in 144: object record, valid the cycle after `rd_en`.
- `seg_vld` out 1: segment valid.
- `seg_rdy` in 1: rasterizer accepts segment.
- `seg_x0`, `seg_y0`, `seg_x1`, `seg_y1` out 16 each: segment endpoints.
- `seg_color` out 8: object colour.
- `seg_obj` out 5: source slot.
- `seg_last` out 1: final segment of this object.
- `busy` out 1: high from accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the frame walk completes.

## Operation
- Record layout: `rd_data[16k+15:16k]` = vk for k=0..7; vertex j = (x=v(2j), y=v(2j+1)). Type is [129:128], colour is [137:130], and [143:138] is ignored.
- Type 0 (point): 1 segment, V0→V0.
- Type 1 (line): 1 segment, V0→V1.
- Type 2 (triangle): 3 segments, V0→V1, V1→V2, V2→V0.
- Type 3 (quad): 4 segments, V0→V1, V1→V2, V2→V3, V3→V0.
- Coordinates pass through unmodified (unsigned, no clipping).
- FSM states:
  - IDLE: on `start`, latch `obj_map` into `map_q`, idx=0, go to SCAN.
  - SCAN: one slot per cycle. If `map_q[idx]`, go to READ. Otherwise, if idx==31 go to DONE, else idx++.
  - READ: when `mat_busy`==0, assert `rd_en` with `rd_addr`=idx for one cycle and go to WAIT. While `mat_busy` is high, hold with `rd_en`=0.
  - WAIT: capture `rd_data` into the record register, set edge counter e=0, go to EMIT.
  - EMIT: drive segment e with `seg_vld`=1. On `seg_vld`&&`seg_rdy`: if this is the last edge, go to DONE when idx==31, else idx++ and go to SCAN; otherwise e++.
  - DONE: `done`=1 for one cycle, then IDLE.
- `seg_last`=1 exactly on the final segment of each object.
- `start` outside IDLE is ignored. `obj_map` changes after the snapshot have no effect on the current walk.
- Asserting `rst_n`=0 at any point, including mid-EMIT, returns to IDLE immediately. No partial `done` is produced.

## Timing
- Reset values: all outputs 0, `map_q`=0, idx=0, state IDLE.
- `busy` rises the cycle after `start` is sampled and falls in the same cycle `done` rises.
- Empty map: SCAN spans 32 cycles, and `done` is high exactly 33 cycles after the `start` edge.
- Per valid object with `seg_rdy` tied high and `mat_busy` low, the cost is SCAN 1 + READ 1 + WAIT 1 + N segment cycles.
- First `seg_vld` appears 3 cycles after SCAN reaches a set slot.
- All segment outputs are registered. While `seg_vld`&&!`seg_rdy`, every `seg_*` output holds stable.
- Back-to-back segments issue one per cycle when `seg_rdy` stays high.
- `rd_en` never asserts in a cycle where `mat_busy`=1.

## Test plan
- Reset: drive `rst_n`=0 with random inputs → all outputs 0; `start` at t0 with `obj_map`=0 → `done` at t0+33, `seg_vld` never asserted, `rd_en` never asserted.
- Quad in slot 0 (v0..v7=100,100,100,200,200,200,200,100, colour 0x3C), `obj_map`=0x1, `seg_rdy`=1 → 4 segments in this order:
  - (100,100)-(100,200)
  - (100,200)-(200,200)
  - (200,200)-(200,100)
  - (200,100)-(100,100), with `seg_last` on the 4th
  - All with `seg_color`=0x3C, `seg_obj`=0.
- `obj_map`=0x7 holding a quad, triangle and line → 4+3+1 segments in slot order, `seg_last` 3 times, `done` once, 3 `rd_en` pulses at `rd_addr` 0, 1, 2.
- Backpressure: quad in slot 5 with `seg_rdy` toggling 1,0,0,1,... → every held segment stays stable while `seg_rdy`=0, and no segment is lost or duplicated.
- Port contention: `mat_busy`=1 for 10 cycles during READ → `rd_en`=0 throughout those cycles, then one `rd_en` at `rd_addr`=slot; a second `start` while `busy` is ignored.
- Point in slot 31 (type 0, V0=(7,9)) → a single segment (7,9)-(7,9) with `seg_last`=1 and `seg_obj`=31, then `done`. Reset asserted mid-EMIT → idle, outputs 0, no `done`.
